// File: rtl/cntr8_serializer.sv
// Parallel-to-serial stage behind the 8-bit up/down counter: captures a word on start
// and shifts it out one bit per clock, MSB or LSB first, with ready/busy/done handshakes.
module cntr8_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_in,
   input  logic             start,
   input  logic             msb_first,
   output logic             ready,
   output logic             busy,
   output logic             s_out,
   output logic             s_valid,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             done,
   output logic [WIDTH-1:0] d_out,
   output logic [1:0]       o_state
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StLoad  = 2'b01,
      StShift = 2'b10,
      StDone  = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             order_q, order_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         sreg_q    <= '0;
         d_out_q   <= '0;
         bit_cnt_q <= '0;
         order_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         d_out_q   <= d_out_d;
         bit_cnt_q <= bit_cnt_d;
         order_q   <= order_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      d_out_d   = d_out_q;
      bit_cnt_d = bit_cnt_q;
      order_d   = order_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StLoad;
               sreg_d    = d_in;
               d_out_d   = d_in;
               order_d   = msb_first;
               bit_cnt_d = '0;
            end
         end
         StLoad: begin
            state_d = StShift;
         end
         StShift: begin
            // Shift toward whichever end feeds s_out, zero-filling the vacated end.
            sreg_d    = order_q ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase
   end

   // Every output decodes registered state only.
   assign ready   = (state_q == StIdle);
   assign busy    = (state_q != StIdle);
   assign s_valid = (state_q == StShift);
   assign s_out   = (state_q == StShift) & (order_q ? sreg_q[WIDTH-1] : sreg_q[0]);
   assign done    = (state_q == StDone);
   assign bit_cnt = bit_cnt_q;
   assign d_out   = d_out_q;
   assign o_state = state_q;

endmodule
